// File: rtl/muxn_reg_arb.sv
// muxn_reg_arb: N-input, WIDTH-bit registered mux with valid/ready on every
// input channel and on the output. The output register is a one-entry buffer
// that can drain and refill in the same cycle, so it sustains one word per cycle.
//
// Run-time modes:
//   i_mode = 0 : select mode, the channel is i_control (no transfer if that
//                channel is not valid or the index is out of range)
//   i_mode = 1 : arbitrate mode, the channel is picked among the valid inputs
//
// Build option MUXN_REG_ARB_RR_EN:
//   defined   -> arbitrate mode is round-robin. The search starts after the
//                last channel granted in arbitrate mode.
//   undefined -> arbitrate mode is fixed priority (lowest index wins), and
//                there is no pointer register.

// Per-channel accept logic. o_ready already includes the channel's valid, so
// o_ready high means this channel transfers this cycle.
module muxn_reg_arb_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             i_mode,
  input  logic [SEL_W-1:0] i_control,
  input  logic             i_arb_hit,
  input  logic             i_valid,
  input  logic             i_load,
  output logic             o_ready
);

  logic sel_hit;

  // An out-of-range i_control matches no lane, so it selects nothing.
  assign sel_hit = (i_control == SEL_W'(IDX));
  assign o_ready = i_load & i_valid & (i_mode ? i_arb_hit : sel_hit);

endmodule

module muxn_reg_arb #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mode,
  input  logic [SEL_W-1:0]   i_control,
  input  logic [N*WIDTH-1:0] i_dat,
  input  logic [N-1:0]       i_valid,
  output logic [N-1:0]       o_ready,
  output logic [WIDTH-1:0]   o_dat,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [SEL_W-1:0]   o_grant
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic [SEL_W-1:0] grant;
  } out_t;

  state_t           state_q, state_d;
  out_t             out_q, out_d;
  logic             load;
  logic             xfer;
  logic [N-1:0]     arb_hit;
  logic [SEL_W-1:0] xfer_idx;
  logic [WIDTH-1:0] xfer_dat;

  // The register can take a word when it is empty or is being drained now.
  // Reset is folded in so that no channel sees ready while reset is held.
  assign load = i_rst_n & ((state_q == EMPTY) | i_ready);

`ifdef MUXN_REG_ARB_RR_EN
  logic [SEL_W-1:0] ptr_q;
  int               best;

  // Distance of channel k from the search start (ptr+1), measured modulo N.
  function automatic int rr_dist(input int k, input int p);
    return (k + N - 1 - p) % N;
  endfunction

  // Round-robin: grant the valid channel nearest after the pointer.
  always_comb begin
    best    = N;
    arb_hit = '0;
    for (int k = 0; k < N; k++)
      if (i_valid[k] && (rr_dist(k, int'(ptr_q)) < best))
        best = rr_dist(k, int'(ptr_q));
    for (int k = 0; k < N; k++)
      arb_hit[k] = i_valid[k] && (rr_dist(k, int'(ptr_q)) == best);
  end

  // The pointer moves only on transfers made in arbitrate mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ptr_q <= SEL_W'(N - 1);
    else if (xfer && i_mode)
      ptr_q <= xfer_idx;
  end
`else
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    arb_hit = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_valid[k]) begin
        arb_hit    = '0;
        arb_hit[k] = 1'b1;
      end
  end
`endif

  for (genvar k = 0; k < N; k++) begin : g_lane
    muxn_reg_arb_lane #(
      .SEL_W (SEL_W),
      .IDX   (k)
    ) u_lane (
      .i_mode    (i_mode),
      .i_control (i_control),
      .i_arb_hit (arb_hit[k]),
      .i_valid   (i_valid[k]),
      .i_load    (load),
      .o_ready   (o_ready[k])
    );
  end

  assign xfer = |o_ready;

  // At most one ready bit is set, so picking the matching lane is a plain mux.
  always_comb begin
    xfer_idx = '0;
    xfer_dat = '0;
    for (int k = 0; k < N; k++)
      if (o_ready[k]) begin
        xfer_idx = SEL_W'(k);
        xfer_dat = i_dat[k*WIDTH +: WIDTH];
      end
  end

  // Buffer next state. A load wins over a drain (pass-through). A plain drain
  // clears only valid; data and grant keep their last values.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (xfer) begin
      state_d     = FULL;
      out_d.dat   = xfer_dat;
      out_d.grant = xfer_idx;
    end else if (i_ready) begin
      state_d = EMPTY;
    end
  end

  // Buffer registers. An asynchronous reset drops any held word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign o_valid = (state_q == FULL);
  assign o_dat   = out_q.dat;
  assign o_grant = out_q.grant;

endmodule
